// File: rtl/rv_cpu_pipelined.sv
`default_nettype none
// ============================================================================
// rv_cpu_pipelined : five-stage in-order RV32I-subset core with internal
//                    instruction memory, register file and data memory.
// Revision: 1.0
// ============================================================================

module rv_ram #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] memory [WORDS];

  always_ff @(posedge clk) begin
    if (we_i) memory[waddr_i] <= wdata_i;
  end

  assign rdata_o = memory[raddr_i];
endmodule

module rv_regfile (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] registers [32];

  always_ff @(posedge clk) begin
    if (!rst_ni) registers <= '{default: '0};
    else if (we_i && wa_i != 5'd0) registers[wa_i] <= wd_i;
  end

  // Write-through so ID sees the value retiring in WB on the same edge.
  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : (we_i && wa_i == ra1_i) ? wd_i : registers[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : (we_i && wa_i == ra2_i) ? wd_i : registers[ra2_i];
endmodule

module rv_cpu_pipelined #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic clk,
  input  logic reset,
  output logic end_program
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BR = 7'b1100011;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3,
                         ALU_XOR = 3'd4, ALU_SLT = 3'd5, ALU_SLL = 3'd6, ALU_SRL = 3'd7;

  logic [31:0] pc_q, pc_d, if_instr;
  logic        halt_fetched_q, halt_fetched_d, end_program_q;
  logic [31:0] cycle_q;
  logic        ifid_valid_q;
  logic [31:0] ifid_pc_q, ifid_instr_q;
  logic [31:0] idex_pc_q, idex_rs1v_q, idex_rs2v_q, idex_imm_q;
  logic [4:0]  idex_rs1_q, idex_rs2_q, idex_rd_q;
  logic [2:0]  idex_alu_q;
  logic        idex_use_imm_q, idex_mr_q, idex_mw_q, idex_rw_q, idex_br_q, idex_bne_q, idex_halt_q;
  logic [31:0] exmem_res_q, exmem_sdata_q;
  logic [4:0]  exmem_rd_q;
  logic        exmem_mr_q, exmem_mw_q, exmem_rw_q, exmem_halt_q;
  logic [31:0] memwb_wdata_q;
  logic [4:0]  memwb_rd_q;
  logic        memwb_rw_q, memwb_halt_q;

  rv_ram #(.WORDS(IMEM_WORDS)) imem (
    .clk(clk), .we_i(1'b0), .waddr_i('0), .wdata_i('0),
    .raddr_i(pc_q[IAW+1:2]), .rdata_o(if_instr)
  );

  // ---------------- ID ----------------
  logic [6:0]  id_op;
  logic [2:0]  id_f3, id_alu;
  logic [6:0]  id_f7;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_imm, id_rv1, id_rv2;
  logic        id_rw, id_mr, id_mw, id_br, id_use_imm, id_use_rs1, id_use_rs2, id_halt, id_stall;

  assign id_op  = ifid_instr_q[6:0];
  assign id_rd  = ifid_instr_q[11:7];
  assign id_f3  = ifid_instr_q[14:12];
  assign id_rs1 = ifid_instr_q[19:15];
  assign id_rs2 = ifid_instr_q[24:20];
  assign id_f7  = ifid_instr_q[31:25];
  assign id_halt = (ifid_instr_q == 32'd0);

  always_comb begin
    id_rw = 1'b0; id_mr = 1'b0; id_mw = 1'b0; id_br = 1'b0;
    id_use_imm = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_alu = ALU_ADD;
    id_imm = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
    case (id_op)
      OP_R: begin
        id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        if (id_f7 == 7'b0000000) begin
          id_rw = 1'b1;
          case (id_f3)
            3'b000: id_alu = ALU_ADD;
            3'b111: id_alu = ALU_AND;
            3'b110: id_alu = ALU_OR;
            3'b100: id_alu = ALU_XOR;
            3'b010: id_alu = ALU_SLT;
            3'b001: id_alu = ALU_SLL;
            3'b101: id_alu = ALU_SRL;
            default: id_rw = 1'b0;
          endcase
        end else if (id_f7 == 7'b0100000 && id_f3 == 3'b000) begin
          id_rw = 1'b1; id_alu = ALU_SUB;
        end
      end
      OP_I: begin
        id_use_rs1 = 1'b1; id_use_imm = 1'b1; id_rw = 1'b1;
        case (id_f3)
          3'b000: id_alu = ALU_ADD;
          3'b111: id_alu = ALU_AND;
          3'b110: id_alu = ALU_OR;
          3'b100: id_alu = ALU_XOR;
          3'b010: id_alu = ALU_SLT;
          default: id_rw = 1'b0;
        endcase
      end
      OP_LW: if (id_f3 == 3'b010) begin
        id_use_rs1 = 1'b1; id_use_imm = 1'b1; id_rw = 1'b1; id_mr = 1'b1;
      end
      OP_SW: if (id_f3 == 3'b010) begin
        id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; id_use_imm = 1'b1; id_mw = 1'b1;
        id_imm = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
      end
      OP_BR: if (id_f3[2:1] == 2'b00) begin
        id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; id_br = 1'b1;
        id_imm = {{20{ifid_instr_q[31]}}, ifid_instr_q[7], ifid_instr_q[30:25],
                  ifid_instr_q[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  assign id_stall = ifid_valid_q && idex_mr_q && idex_rd_q != 5'd0 &&
                    ((id_use_rs1 && id_rs1 == idex_rd_q) || (id_use_rs2 && id_rs2 == idex_rd_q));

  rv_regfile reg_file (
    .clk(clk), .rst_ni(reset), .ra1_i(id_rs1), .ra2_i(id_rs2),
    .we_i(memwb_rw_q), .wa_i(memwb_rd_q), .wd_i(memwb_wdata_q),
    .rd1_o(id_rv1), .rd2_o(id_rv2)
  );

  // ---------------- EX ----------------
  logic [31:0] ex_a, ex_fb, ex_b, ex_res, ex_target;
  logic        ex_taken;

  always_comb begin
    ex_a = idex_rs1v_q;
    if (exmem_rw_q && exmem_rd_q != 5'd0 && exmem_rd_q == idex_rs1_q) ex_a = exmem_res_q;
    else if (memwb_rw_q && memwb_rd_q != 5'd0 && memwb_rd_q == idex_rs1_q) ex_a = memwb_wdata_q;
    ex_fb = idex_rs2v_q;
    if (exmem_rw_q && exmem_rd_q != 5'd0 && exmem_rd_q == idex_rs2_q) ex_fb = exmem_res_q;
    else if (memwb_rw_q && memwb_rd_q != 5'd0 && memwb_rd_q == idex_rs2_q) ex_fb = memwb_wdata_q;
    ex_b = idex_use_imm_q ? idex_imm_q : ex_fb;
    case (idex_alu_q)
      ALU_SUB: ex_res = ex_a - ex_b;
      ALU_AND: ex_res = ex_a & ex_b;
      ALU_OR:  ex_res = ex_a | ex_b;
      ALU_XOR: ex_res = ex_a ^ ex_b;
      ALU_SLT: ex_res = {31'd0, $signed(ex_a) < $signed(ex_b)};
      ALU_SLL: ex_res = ex_a << ex_b[4:0];
      ALU_SRL: ex_res = ex_a >> ex_b[4:0];
      default: ex_res = ex_a + ex_b;
    endcase
  end

  assign ex_taken  = idex_br_q && ((ex_a == ex_fb) ^ idex_bne_q);
  assign ex_target = idex_pc_q + idex_imm_q;

  // ---------------- MEM ----------------
  logic [31:0] mem_rdata;

  rv_ram #(.WORDS(DMEM_WORDS)) dmem (
    .clk(clk), .we_i(exmem_mw_q), .waddr_i(exmem_res_q[DAW+1:2]), .wdata_i(exmem_sdata_q),
    .raddr_i(exmem_res_q[DAW+1:2]), .rdata_o(mem_rdata)
  );

  // ---------------- IF ----------------
  always_comb begin
    pc_d = pc_q;
    halt_fetched_d = halt_fetched_q;
    if (ex_taken) begin
      pc_d = ex_target;
      halt_fetched_d = 1'b0;
    end else if (!id_stall && !halt_fetched_q) begin
      if (if_instr == 32'd0) halt_fetched_d = 1'b1;
      else pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= '0; halt_fetched_q <= 1'b0; end_program_q <= 1'b0; cycle_q <= '0;
      ifid_valid_q <= 1'b0;
      idex_rw_q <= 1'b0; idex_mr_q <= 1'b0; idex_mw_q <= 1'b0; idex_br_q <= 1'b0; idex_halt_q <= 1'b0;
      exmem_rw_q <= 1'b0; exmem_mr_q <= 1'b0; exmem_mw_q <= 1'b0; exmem_halt_q <= 1'b0;
      memwb_rw_q <= 1'b0; memwb_halt_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      halt_fetched_q <= halt_fetched_d;
      end_program_q <= end_program_q | memwb_halt_q;
      if (!end_program_q) cycle_q <= cycle_q + 32'd1;

      if (ex_taken) ifid_valid_q <= 1'b0;
      else if (!id_stall) begin
        ifid_valid_q <= !halt_fetched_q;
        ifid_pc_q    <= pc_q;
        ifid_instr_q <= if_instr;
      end

      // Wrong-path slots and load-use stalls enter EX as bubbles.
      if (ex_taken || id_stall || !ifid_valid_q) begin
        idex_rw_q <= 1'b0; idex_mr_q <= 1'b0; idex_mw_q <= 1'b0; idex_br_q <= 1'b0; idex_halt_q <= 1'b0;
      end else begin
        idex_rw_q <= id_rw; idex_mr_q <= id_mr; idex_mw_q <= id_mw; idex_br_q <= id_br; idex_halt_q <= id_halt;
      end
      idex_pc_q <= ifid_pc_q; idex_rs1v_q <= id_rv1; idex_rs2v_q <= id_rv2; idex_imm_q <= id_imm;
      idex_rs1_q <= id_rs1; idex_rs2_q <= id_rs2; idex_rd_q <= id_rd; idex_alu_q <= id_alu;
      idex_use_imm_q <= id_use_imm; idex_bne_q <= id_f3[0];

      exmem_rw_q <= idex_rw_q; exmem_mr_q <= idex_mr_q; exmem_mw_q <= idex_mw_q; exmem_halt_q <= idex_halt_q;
      exmem_res_q <= ex_res; exmem_sdata_q <= ex_fb; exmem_rd_q <= idex_rd_q;

      memwb_rw_q <= exmem_rw_q; memwb_halt_q <= exmem_halt_q; memwb_rd_q <= exmem_rd_q;
      memwb_wdata_q <= exmem_mr_q ? mem_rdata : exmem_res_q;
    end
  end

  assign end_program = end_program_q;
endmodule
`default_nettype wire

// File: tb/tb_rv_cpu_pipelined.sv
`default_nettype none
// ============================================================================
// tb_rv_cpu_pipelined : directed program-level checks of rv_cpu_pipelined.
// Revision: 1.0
// ============================================================================
module tb_rv_cpu_pipelined;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic end_program;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc;

  localparam logic [6:0] OP_I = 7'b0010011, OP_LW = 7'b0000011;

  rv_cpu_pipelined #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
    .clk(clk), .reset(reset), .end_program(end_program)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    logic [31:0] im;
    im = imm;
    return {im[11:0], 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] im;
    im = imm;
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
    logic [31:0] im;
    im = imm;
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] rf(input int i);
    return dut.reg_file.registers[i];
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) dut.imem.memory[i] = 32'd0;
  endtask

  // Hold reset for two edges while the program is loaded, release on a negedge.
  task automatic hold_reset();
    reset = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_end(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (end_program) break;
    end
  endtask

  task automatic load_basic();
    clear_imem();
    dut.imem.memory[0] = 32'h00000013;
    for (int k = 1; k <= 5; k++) dut.imem.memory[k] = enc_i(k, 0, 3'b000, k, OP_I);
    dut.imem.memory[6] = 32'd0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) dut.dmem.memory[i] = 32'hA5A5_0000 + i;

    // ---- reset state ----
    load_basic();
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_val("rst_end_program", {31'd0, end_program}, 32'd0);
    check_val("rst_x1", rf(1), 32'd0);

    // ---- straight-line addi program ----
    hold_reset();
    wait_end(cyc);
    check_val("basic_cycles", cyc, 11);
    for (int i = 0; i < 32; i++)
      check_val($sformatf("basic_x%0d", i), rf(i), (i >= 1 && i <= 5) ? i : 0);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("basic_dmem%0d", i), dut.dmem.memory[i], 32'hA5A5_0000 + i);
    repeat (3) @(posedge clk);
    #1 check_val("basic_sticky", {31'd0, end_program}, 32'd1);

    // ---- back-to-back forwarding ----
    clear_imem();
    dut.imem.memory[0] = enc_i(7, 0, 3'b000, 1, OP_I);
    dut.imem.memory[1] = enc_r(7'b0, 1, 1, 3'b000, 2);
    dut.imem.memory[2] = enc_r(7'b0, 1, 2, 3'b000, 3);
    hold_reset();
    wait_end(cyc);
    check_val("fwd_cycles", cyc, 8);
    check_val("fwd_x2", rf(2), 32'd14);
    check_val("fwd_x3", rf(3), 32'd21);

    // ---- store, load-use stall ----
    clear_imem();
    dut.imem.memory[0] = enc_i(42, 0, 3'b000, 1, OP_I);
    dut.imem.memory[1] = enc_s(8, 1, 0);
    dut.imem.memory[2] = enc_i(8, 0, 3'b010, 2, OP_LW);
    dut.imem.memory[3] = enc_i(1, 2, 3'b000, 3, OP_I);
    hold_reset();
    wait_end(cyc);
    check_val("ldu_cycles", cyc, 10);
    check_val("ldu_dmem2", dut.dmem.memory[2], 32'd42);
    check_val("ldu_x2", rf(2), 32'd42);
    check_val("ldu_x3", rf(3), 32'd43);

    // ---- taken branch squashes one instruction ----
    clear_imem();
    dut.imem.memory[0] = enc_i(1, 0, 3'b000, 1, OP_I);
    dut.imem.memory[1] = enc_b(8, 1, 1, 3'b000);
    dut.imem.memory[2] = enc_i(99, 0, 3'b000, 2, OP_I);
    dut.imem.memory[3] = enc_i(5, 0, 3'b000, 3, OP_I);
    hold_reset();
    wait_end(cyc);
    check_val("br_cycles", cyc, 10);
    check_val("br_x1", rf(1), 32'd1);
    check_val("br_x2", rf(2), 32'd0);
    check_val("br_x3", rf(3), 32'd5);

    // ---- halt on the wrong path is ignored ----
    clear_imem();
    dut.imem.memory[0] = enc_b(8, 0, 0, 3'b000);
    dut.imem.memory[1] = 32'd0;
    dut.imem.memory[2] = enc_i(3, 0, 3'b000, 4, OP_I);
    hold_reset();
    wait_end(cyc);
    check_val("wph_cycles", cyc, 9);
    check_val("wph_x4", rf(4), 32'd3);

    // ---- ALU coverage, not-taken bne, x0 write, wrapped store ----
    clear_imem();
    dut.imem.memory[0]  = enc_i(-5, 0, 3'b000, 1, OP_I);
    dut.imem.memory[1]  = enc_i(3, 0, 3'b000, 2, OP_I);
    dut.imem.memory[2]  = enc_r(7'b0100000, 1, 2, 3'b000, 3);
    dut.imem.memory[3]  = enc_r(7'b0, 2, 1, 3'b111, 4);
    dut.imem.memory[4]  = enc_r(7'b0, 2, 1, 3'b110, 5);
    dut.imem.memory[5]  = enc_r(7'b0, 2, 1, 3'b100, 6);
    dut.imem.memory[6]  = enc_r(7'b0, 2, 1, 3'b010, 7);
    dut.imem.memory[7]  = enc_r(7'b0, 2, 2, 3'b001, 8);
    dut.imem.memory[8]  = enc_r(7'b0, 2, 1, 3'b101, 9);
    dut.imem.memory[9]  = enc_i(-4, 1, 3'b010, 10, OP_I);
    dut.imem.memory[10] = enc_i(255, 2, 3'b100, 11, OP_I);
    dut.imem.memory[11] = enc_i(240, 1, 3'b111, 12, OP_I);
    dut.imem.memory[12] = enc_i(1792, 2, 3'b110, 13, OP_I);
    dut.imem.memory[13] = enc_b(8, 2, 2, 3'b001);
    dut.imem.memory[14] = enc_i(9, 0, 3'b000, 14, OP_I);
    dut.imem.memory[15] = enc_i(5, 0, 3'b000, 0, OP_I);
    dut.imem.memory[16] = enc_s(1036, 2, 0);
    dut.imem.memory[17] = enc_i(14, 0, 3'b010, 15, OP_LW);
    hold_reset();
    wait_end(cyc);
    check_val("alu_cycles", cyc, 23);
    check_val("alu_sub",  rf(3),  32'd8);
    check_val("alu_and",  rf(4),  32'd3);
    check_val("alu_or",   rf(5),  32'hFFFF_FFFB);
    check_val("alu_xor",  rf(6),  32'hFFFF_FFF8);
    check_val("alu_slt",  rf(7),  32'd1);
    check_val("alu_sll",  rf(8),  32'd24);
    check_val("alu_srl",  rf(9),  32'h1FFF_FFFF);
    check_val("alu_slti", rf(10), 32'd1);
    check_val("alu_xori", rf(11), 32'h0000_00FC);
    check_val("alu_andi", rf(12), 32'h0000_00F0);
    check_val("alu_ori",  rf(13), 32'h0000_0703);
    check_val("alu_bne_nt", rf(14), 32'd9);
    check_val("alu_x0",   rf(0),  32'd0);
    check_val("alu_wrap_dmem3", dut.dmem.memory[3], 32'd3);
    check_val("alu_lw_x15", rf(15), 32'd3);

    // ---- reset while the pipeline is full ----
    load_basic();
    hold_reset();
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("mid_x1", rf(1), 32'd0);
    check_val("mid_end_program", {31'd0, end_program}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_end(cyc);
    check_val("mid_cycles", cyc, 11);
    check_val("mid_x3", rf(3), 32'd3);
    check_val("mid_x5", rf(5), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
